// File: rtl/video_timing_gen.sv
// Runtime-programmable video timing generator: sync/blank/DE, coordinates and strobes.
// Optional define VTG_FRAME_CNT_EN adds a 32-bit frame counter output o_frame_cnt.
module video_timing_gen #(
  parameter int CNT_W      = 12,
  parameter int DEF_H_ACT  = 640,
  parameter int DEF_H_FP   = 16,
  parameter int DEF_H_SYNC = 96,
  parameter int DEF_H_BP   = 48,
  parameter int DEF_V_ACT  = 480,
  parameter int DEF_V_FP   = 10,
  parameter int DEF_V_SYNC = 2,
  parameter int DEF_V_BP   = 33,
  parameter bit DEF_HPOL   = 1'b0,
  parameter bit DEF_VPOL   = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [CNT_W-1:0] i_cfg_h_act,
  input  logic [CNT_W-1:0] i_cfg_h_fp,
  input  logic [CNT_W-1:0] i_cfg_h_sync,
  input  logic [CNT_W-1:0] i_cfg_h_bp,
  input  logic [CNT_W-1:0] i_cfg_v_act,
  input  logic [CNT_W-1:0] i_cfg_v_fp,
  input  logic [CNT_W-1:0] i_cfg_v_sync,
  input  logic [CNT_W-1:0] i_cfg_v_bp,
  input  logic             i_cfg_hpol,
  input  logic             i_cfg_vpol,
  output logic             o_cfg_err,
  output logic             o_cfg_applied,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_hblank,
  output logic             o_vblank,
  output logic             o_de,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_line_start,
  output logic             o_frame_start
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [31:0]      o_frame_cnt
`endif
);

  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] MAX_T = {2'b00, {CNT_W{1'b1}}};

  typedef struct packed {
    logic [CNT_W-1:0] h_act, h_fp, h_sync, h_bp;
    logic [CNT_W-1:0] v_act, v_fp, v_sync, v_bp;
    logic             hpol, vpol;
  } timing_t;

  localparam timing_t DEF_T = '{
    h_act: CNT_W'(DEF_H_ACT), h_fp: CNT_W'(DEF_H_FP),
    h_sync: CNT_W'(DEF_H_SYNC), h_bp: CNT_W'(DEF_H_BP),
    v_act: CNT_W'(DEF_V_ACT), v_fp: CNT_W'(DEF_V_FP),
    v_sync: CNT_W'(DEF_V_SYNC), v_bp: CNT_W'(DEF_V_BP),
    hpol: DEF_HPOL, vpol: DEF_VPOL};

  function automatic logic [SW-1:0] zx(input logic [CNT_W-1:0] a);
    return {2'b00, a};
  endfunction

  timing_t          act_q, pend_q, cfg_in;
  logic             pend_vld_q, apply_q, err_q, applied_q;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0] x_q, y_q;
  logic             hsync_q, vsync_q, hblank_q, vblank_q, de_q, ls_q, fs_q;

  logic [SW-1:0]    in_ht, in_vt, h_s0, h_s1, a_ht, v_s0, v_s1, a_vt;
  logic             cfg_legal, accept, h_last, v_last, apply_now;
  logic             hb, vb, hs_on, vs_on, at_origin;

  always_comb begin
    cfg_in = '{
      h_act: i_cfg_h_act, h_fp: i_cfg_h_fp, h_sync: i_cfg_h_sync, h_bp: i_cfg_h_bp,
      v_act: i_cfg_v_act, v_fp: i_cfg_v_fp, v_sync: i_cfg_v_sync, v_bp: i_cfg_v_bp,
      hpol: i_cfg_hpol, vpol: i_cfg_vpol};
  end

  // Totals carry two guard bits so a wrapped sum can't masquerade as legal.
  always_comb begin
    in_ht = zx(cfg_in.h_act) + zx(cfg_in.h_fp) + zx(cfg_in.h_sync) + zx(cfg_in.h_bp);
    in_vt = zx(cfg_in.v_act) + zx(cfg_in.v_fp) + zx(cfg_in.v_sync) + zx(cfg_in.v_bp);
    cfg_legal = (cfg_in.h_act != '0) && (cfg_in.h_fp != '0) &&
                (cfg_in.h_sync != '0) && (cfg_in.h_bp != '0) &&
                (cfg_in.v_act != '0) && (cfg_in.v_fp != '0) &&
                (cfg_in.v_sync != '0) && (cfg_in.v_bp != '0) &&
                (in_ht <= MAX_T) && (in_vt <= MAX_T);
  end

  assign o_cfg_ready = !pend_vld_q;
  assign accept      = i_cfg_valid && o_cfg_ready;

  always_comb begin
    h_s0 = zx(act_q.h_act) + zx(act_q.h_fp);
    h_s1 = h_s0 + zx(act_q.h_sync);
    a_ht = h_s1 + zx(act_q.h_bp);
    v_s0 = zx(act_q.v_act) + zx(act_q.v_fp);
    v_s1 = v_s0 + zx(act_q.v_sync);
    a_vt = v_s1 + zx(act_q.v_bp);
    h_last    = zx(h_q) == (a_ht - SW'(1));
    v_last    = zx(v_q) == (a_vt - SW'(1));
    apply_now = h_last && v_last && pend_vld_q;
    hb        = h_q >= act_q.h_act;
    vb        = v_q >= act_q.v_act;
    hs_on     = (zx(h_q) >= h_s0) && (zx(h_q) < h_s1);
    vs_on     = (zx(v_q) >= v_s0) && (zx(v_q) < v_s1);
    at_origin = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    h_d = h_q + CNT_W'(1);
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + CNT_W'(1);
    end
  end

  // New timing takes effect on the wrap; pending/ready are released one cycle
  // later so o_cfg_applied and o_cfg_ready line up with o_frame_start.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      act_q      <= DEF_T;
      pend_q     <= DEF_T;
      pend_vld_q <= 1'b0;
      apply_q    <= 1'b0;
      err_q      <= 1'b0;
      applied_q  <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      apply_q   <= apply_now;
      applied_q <= apply_q;
      err_q     <= accept && !cfg_legal;
      if (apply_now) act_q <= pend_q;
      if (apply_q) begin
        pend_vld_q <= 1'b0;
      end else if (accept && cfg_legal) begin
        pend_q     <= cfg_in;
        pend_vld_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~DEF_HPOL;
      vsync_q  <= ~DEF_VPOL;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      x_q      <= h_q;
      y_q      <= v_q;
      hsync_q  <= hs_on ? act_q.hpol : ~act_q.hpol;
      vsync_q  <= vs_on ? act_q.vpol : ~act_q.vpol;
      hblank_q <= hb;
      vblank_q <= vb;
      de_q     <= !hb && !vb;
      ls_q     <= h_q == '0;
      fs_q     <= at_origin;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [31:0] fcnt_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       fcnt_q <= '0;
    else if (at_origin) fcnt_q <= fcnt_q + 32'd1;
  end
  assign o_frame_cnt = fcnt_q;
`endif

  assign o_cfg_err     = err_q;
  assign o_cfg_applied = applied_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_hblank      = hblank_q;
  assign o_vblank      = vblank_q;
  assign o_de          = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_line_start  = ls_q;
  assign o_frame_start = fs_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor to the fixed-mode sync generator. Produces hsync/vsync/blank/DE plus pixel coordinates and line/frame strobes for the DVI/LCD output path. Timing is runtime-reprogrammable through a valid/ready config port. New timings are shadowed and applied only at the frame boundary, so the transmitter never sees a torn frame.

Parameters:
CNT_W, 12, width of the h/v counters, coordinate outputs and config fields.
DEF_H_ACT, 640, reset horizontal active pixels.
DEF_H_FP, 16, reset horizontal front porch.
DEF_H_SYNC, 96, reset horizontal sync width.
DEF_H_BP, 48, reset horizontal back porch.
DEF_V_ACT, 480, reset vertical active lines.
DEF_V_FP, 10, reset vertical front porch.
DEF_V_SYNC, 2, reset vertical sync width.
DEF_V_BP, 33, reset vertical back porch.
DEF_HPOL, 0, reset hsync active level (0 = active-low).
DEF_VPOL, 0, reset vsync active level.

Ports:
i_clk  in  1  pixel clock.
i_rst_n  in  1  reset.
i_cfg_valid  in  1  new timing offered.
o_cfg_ready  out  1  no update pending; offer can be taken.
i_cfg_h_act, i_cfg_h_fp, i_cfg_h_sync, i_cfg_h_bp  in  CNT_W each  horizontal timing.
i_cfg_v_act, i_cfg_v_fp, i_cfg_v_sync, i_cfg_v_bp  in  CNT_W each  vertical timing.
i_cfg_hpol, i_cfg_vpol  in  1 each  sync active levels.
o_cfg_err  out  1  one-cycle pulse: offered config rejected.
o_cfg_applied  out  1  one-cycle pulse: pending config became active.
o_hsync, o_vsync  out  1 each  syncs at configured polarity.
o_hblank, o_vblank, o_de  out  1 each  blanking and data enable.
o_x, o_y  out  CNT_W each  current h/v counter value.
o_line_start  out  1  pulse at h=0.
o_frame_start  out  1  pulse at h=0 and v=0.

Behaviour:
- Reset is synchronous and active-low on i_rst_n, clocked by i_clk.
- Reset: active timing = DEF_* parameters; pending register empty; h = v = 0.
- Output reset values: o_cfg_ready=1, o_cfg_err=0, o_cfg_applied=0, o_de=0, o_hblank=1, o_vblank=1, o_x=0, o_y=0, o_line_start=0, o_frame_start=0, o_hsync=~DEF_HPOL, o_vsync=~DEF_VPOL.
- Line order is active, front porch, sync, back porch. HT = h_act + h_fp + h_sync + h_bp; VT likewise.
- h counts 0..HT-1 and wraps to 0. v increments when h = HT-1 and wraps to 0 after VT-1.
- Every output is registered: a function of the (h, v) value on the previous cycle, so latency is 1 clock and all outputs are mutually aligned.
- hblank = (h >= h_act); vblank = (v >= v_act); de = !hblank && !vblank.
- hsync is asserted when h_act+h_fp <= h < h_act+h_fp+h_sync, driven at level hpol, otherwise ~hpol. vsync uses the same rule on v with vpol. vsync changes on line boundaries only.
- Config accept: i_cfg_valid && o_cfg_ready in the same cycle.
  - Legal config: all fields copied to pending; o_cfg_ready=0 the next cycle.
  - Illegal config: o_cfg_err=1 the next cycle; nothing captured; o_cfg_ready stays 1.
  - Illegal means any field = 0, or HT or VT > 2^CNT_W - 1. Sums are computed at CNT_W+2 bits so overflow is detected.
- Apply: in the cycle where h = HT-1 and v = VT-1 with pending held, the active timing is loaded from pending for the next cycle. The counters wrap to 0 as normal. o_cfg_applied and o_cfg_ready=1 follow one cycle later, aligned with o_frame_start.
- An accept and the frame-boundary cycle coinciding: the new config is captured into pending and applied at the following frame boundary, not the current one.
- Reset asserted mid-frame or with an update pending: pending is discarded and DEF_* timing is restored.
- o_cfg_ready depends only on state, never combinationally on i_cfg_valid.

Optional Feature:
Macro VTG_FRAME_CNT_EN.
- Defined: adds output o_frame_cnt (32 bits).
  - Reset value 0.
  - Increments by 1 in the same registered cycle o_frame_start is asserted, so the first frame after reset reads 1.
  - Wraps modulo 2^32.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset defaults: release reset -> o_hsync low for h 656..751, o_de high for x 0..639, y 0..479; line period 800 clocks, frame 525 lines; o_frame_start period 420000 clocks.
- Small mode: offer h 8/2/2/4, v 4/1/1/2, hpol=1, vpol=1 mid-frame -> o_cfg_ready drops; the current frame completes at 640x480 timing; o_cfg_applied coincides with o_frame_start; then line period 16, o_hsync high at x 10..11, o_de for x 0..7, y 0..3; frame period 128 clocks.
- Illegal config: offer h_sync=0, then separately h_act=4095 with h_fp=1 (CNT_W=12) -> o_cfg_err pulses each time; o_cfg_ready stays 1; timing unchanged.
- Boundary collision: accept a legal config exactly in the h=HT-1, v=VT-1 cycle -> no change at that wrap; applied at the next frame start.
- Reset mid-update: pending config, then i_rst_n low 3 cycles -> outputs at reset values; after release, 640x480 timing resumes and o_cfg_ready=1.
- VTG_FRAME_CNT_EN defined, small mode, 5 frames -> o_frame_cnt reads 1..5, incrementing with each o_frame_start.
